// File: rtl/triangle_area_seq.sv
// Shoelace-formula sequencer: drives a shared external MAC through two passes of three
// products and reports |sum1 - sum2| as the doubled triangle area.
module triangle_area_seq #(
   parameter int unsigned COORD_W = 10,
   parameter int unsigned ACC_W   = 2*COORD_W+2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   input  logic [COORD_W-1:0] x2,
   input  logic [COORD_W-1:0] y2,
   output logic               ready,
   output logic               busy,
   output logic [COORD_W-1:0] mac_x,
   output logic [COORD_W-1:0] mac_y,
   output logic               mac_en,
   output logic               mac_clr,
   input  logic [ACC_W-1:0]   mac_acc,
   output logic               done,
   output logic [ACC_W-1:0]   area2,
   output logic [ACC_W-2:0]   area,
   output logic               half,
   output logic               degenerate
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_CLR  = 4'd1,
      S_P1A  = 4'd2,
      S_P1B  = 4'd3,
      S_P1C  = 4'd4,
      S_CAP1 = 4'd5,
      S_P2A  = 4'd6,
      S_P2B  = 4'd7,
      S_P2C  = 4'd8,
      S_CAP2 = 4'd9,
      S_DONE = 4'd10
   } state_e;

   state_e state_q, state_d;

   logic [COORD_W-1:0] vx0_q, vy0_q, vx1_q, vy1_q, vx2_q, vy2_q;
   logic [COORD_W-1:0] vx0_d, vy0_d, vx1_d, vy1_d, vx2_d, vy2_d;
   logic [ACC_W-1:0]   sum1_q, sum1_d;
   logic [ACC_W-1:0]   area2_q, area2_d;
   logic [ACC_W-2:0]   area_q, area_d;
   logic               half_q, half_d;
   logic               degen_q, degen_d;

   logic               accept;
   logic [ACC_W-1:0]   diff;

   assign accept = start && (state_q == S_IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state: fixed 11-cycle walk once a request is accepted
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_CLR;
         S_CLR:   state_d = S_P1A;
         S_P1A:   state_d = S_P1B;
         S_P1B:   state_d = S_P1C;
         S_P1C:   state_d = S_CAP1;
         S_CAP1:  state_d = S_P2A;
         S_P2A:   state_d = S_P2B;
         S_P2B:   state_d = S_P2C;
         S_P2C:   state_d = S_CAP2;
         S_CAP2:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore outputs; reset forces a MAC clear so the external accumulator restarts clean
   always_comb begin
      ready   = 1'b0;
      busy    = 1'b1;
      done    = 1'b0;
      mac_en  = 1'b0;
      mac_clr = 1'b0;
      mac_x   = '0;
      mac_y   = '0;
      case (state_q)
         S_IDLE: begin
            ready = 1'b1;
            busy  = 1'b0;
         end
         S_CLR:  mac_clr = 1'b1;
         S_P1A:  begin mac_en = 1'b1; mac_x = vx0_q; mac_y = vy1_q; end
         S_P1B:  begin mac_en = 1'b1; mac_x = vx1_q; mac_y = vy2_q; end
         S_P1C:  begin mac_en = 1'b1; mac_x = vx2_q; mac_y = vy0_q; end
         S_CAP1: mac_clr = 1'b1;
         S_P2A:  begin mac_en = 1'b1; mac_x = vx1_q; mac_y = vy0_q; end
         S_P2B:  begin mac_en = 1'b1; mac_x = vx2_q; mac_y = vy1_q; end
         S_P2C:  begin mac_en = 1'b1; mac_x = vx0_q; mac_y = vy2_q; end
         S_CAP2: ;
         S_DONE: done = 1'b1;
         default: begin
            ready = 1'b0;
            busy  = 1'b0;
         end
      endcase
      if (reset) mac_clr = 1'b1;
   end

   // Sums never exceed 3*(2^COORD_W-1)^2, so the magnitude difference cannot wrap
   assign diff = (mac_acc >= sum1_q) ? (mac_acc - sum1_q) : (sum1_q - mac_acc);

   // Datapath next-state: vertex capture, pass-1 sum, final results
   always_comb begin
      vx0_d   = vx0_q;
      vy0_d   = vy0_q;
      vx1_d   = vx1_q;
      vy1_d   = vy1_q;
      vx2_d   = vx2_q;
      vy2_d   = vy2_q;
      sum1_d  = sum1_q;
      area2_d = area2_q;
      area_d  = area_q;
      half_d  = half_q;
      degen_d = degen_q;
      if (accept) begin
         vx0_d = x0;
         vy0_d = y0;
         vx1_d = x1;
         vy1_d = y1;
         vx2_d = x2;
         vy2_d = y2;
      end
      if (state_q == S_CAP1) sum1_d = mac_acc;
      if (state_q == S_CAP2) begin
         area2_d = diff;
         area_d  = diff[ACC_W-1:1];
         half_d  = diff[0];
         degen_d = (diff == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vx0_q   <= '0;
         vy0_q   <= '0;
         vx1_q   <= '0;
         vy1_q   <= '0;
         vx2_q   <= '0;
         vy2_q   <= '0;
         sum1_q  <= '0;
         area2_q <= '0;
         area_q  <= '0;
         half_q  <= 1'b0;
         degen_q <= 1'b0;
      end else begin
         vx0_q   <= vx0_d;
         vy0_q   <= vy0_d;
         vx1_q   <= vx1_d;
         vy1_q   <= vy1_d;
         vx2_q   <= vx2_d;
         vy2_q   <= vy2_d;
         sum1_q  <= sum1_d;
         area2_q <= area2_d;
         area_q  <= area_d;
         half_q  <= half_d;
         degen_q <= degen_d;
      end
   end

   assign area2      = area2_q;
   assign area       = area_q;
   assign half       = half_q;
   assign degenerate = degen_q;

endmodule
